// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits + odd parity + stop
// clocked by the device, then ACK check. Drives the bus through open-drain pull-low enables.
module ps2_host_transmitter #(
  parameter int unsigned CLOCK_SPEED    = 8333333,
  parameter int unsigned INHIBIT_CYCLES = CLOCK_SPEED / 10000,
  parameter int unsigned TIMEOUT_CYCLES = CLOCK_SPEED / 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic [7:0] txData,
  input  logic       txStart,
  output logic       txBusy,
  output logic       txDone,
  output logic       txError,
  output logic       ps2ClkDriveLow,
  output logic       ps2DatDriveLow
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           state, state_n;
  logic             clk_s1, clk_s2, clk_prev;
  logic             dat_s1, dat_s2;
  logic [9:0]       shift, shift_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0] cnt, cnt_n, tmo_next;
  logic             out_bit, out_bit_n;
  logic             dev_fall, dev_edge, timed_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      cnt      <= '0;
      out_bit  <= 1'b1;
    end else begin
      clk_s1   <= PS2_CLK;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= PS2_DAT;
      dat_s2   <= dat_s1;
      state    <= state_n;
      shift    <= shift_n;
      bit_cnt  <= bit_cnt_n;
      cnt      <= cnt_n;
      out_bit  <= out_bit_n;
    end
  end

  assign dev_fall  = clk_prev & ~clk_s2;
  assign dev_edge  = clk_prev ^ clk_s2;
  // Timeout counter restarts on either device clock edge and holds at its last value.
  assign tmo_next  = dev_edge ? '0 : ((cnt == TMO_LAST) ? cnt : cnt + CNT_W'(1));
  assign timed_out = (cnt == TMO_LAST) && !dev_edge;
  assign txBusy    = (state != IDLE);

  always_comb begin
    state_n        = state;
    shift_n        = shift;
    bit_cnt_n      = bit_cnt;
    cnt_n          = cnt;
    out_bit_n      = out_bit;
    ps2ClkDriveLow = 1'b0;
    ps2DatDriveLow = 1'b0;
    txDone         = 1'b0;
    txError        = 1'b0;
    case (state)
      IDLE: begin
        if (txStart) begin
          state_n   = INHIBIT;
          shift_n   = {1'b1, ~^txData, txData};
          bit_cnt_n = '0;
          cnt_n     = '0;
          out_bit_n = 1'b0;
        end
      end
      INHIBIT: begin
        ps2ClkDriveLow = 1'b1;
        if (cnt == INH_LAST) begin
          ps2DatDriveLow = 1'b1;
          state_n        = RTS;
          cnt_n          = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RTS: begin
        ps2DatDriveLow = ~out_bit;
        cnt_n          = tmo_next;
        if (timed_out) begin
          ps2DatDriveLow = 1'b0;
          txError        = 1'b1;
          state_n        = IDLE;
        end else if (dev_fall) begin
          out_bit_n = shift[0];
          shift_n   = {1'b0, shift[9:1]};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) state_n = ACK;
        end
      end
      ACK: begin
        cnt_n = tmo_next;
        if (timed_out) begin
          txError = 1'b1;
          state_n = IDLE;
        end else if (dev_fall) begin
          if (dat_s2) begin
            txError = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_n = tmo_next;
        if (clk_s2 && dat_s2) begin
          txDone  = 1'b1;
          state_n = IDLE;
        end else if (timed_out) begin
          txError = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (rst) begin
      txDone  = 1'b0;
      txError = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: a PS/2 device model clocks frames, collects the bits on
// its rising edges and answers ACK/NACK; results are compared against hand-computed frames.
module tb_ps2_host_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       PS2_CLK, PS2_DAT;
  logic [7:0] txData;
  logic       txStart;
  logic       txBusy, txDone, txError, ps2ClkDriveLow, ps2DatDriveLow;
  logic       dev_clk_low, dev_dat_low;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic pulse_prev = 1'b0;
  logic busy_at_pulse = 1'b0, busy_after_pulse = 1'b1, rel_after_pulse = 1'b0;

  assign PS2_CLK = !(ps2ClkDriveLow || dev_clk_low);
  assign PS2_DAT = !(ps2DatDriveLow || dev_dat_low);

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(20),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PS2_CLK       (PS2_CLK),
    .PS2_DAT       (PS2_DAT),
    .txData        (txData),
    .txStart       (txStart),
    .txBusy        (txBusy),
    .txDone        (txDone),
    .txError       (txError),
    .ps2ClkDriveLow(ps2ClkDriveLow),
    .ps2DatDriveLow(ps2DatDriveLow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pulse_prev) begin
      busy_after_pulse = txBusy;
      rel_after_pulse  = !ps2ClkDriveLow && !ps2DatDriveLow;
    end
    if (txDone || txError) busy_at_pulse = txBusy;
    pulse_prev = txDone || txError;
    if (txDone) done_cnt++;
    if (txError) err_cnt++;
    if (txDone && txError) both_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (txBusy && w < 400) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk(name, {31'd0, txBusy}, 32'd0);
  endtask

  // stop_after > 0: device stops clocking after that many falling edges; gap counts
  // negedges from its final rising edge to txError. poke: re-request with 0x55 mid-frame.
  task automatic run_frame(input logic [7:0] d, input bit nack, input int stop_after, input bit poke,
                           output logic [9:0] seen, output int inhib_len, output logic dat_early,
                           output logic start_bit, output int nd, output int ne, output int gap);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    seen = '0;
    gap = 0;
    @(negedge clk);
    txData  = d;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    txData  = ~d;
    dat_early = ps2DatDriveLow;
    inhib_len = 0;
    while (ps2ClkDriveLow && inhib_len < 1000) begin
      inhib_len++;
      @(negedge clk);
    end
    start_bit = PS2_DAT;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      if (poke && i == 3) begin
        @(negedge clk);
        txData  = 8'h55;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        txData  = ~d;
        repeat (3) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
      dev_clk_low = 1'b0;
      if (i == stop_after) begin
        while (!txError && gap < 1000) begin
          @(negedge clk);
          gap++;
        end
        break;
      end
      repeat (2) @(negedge clk);
      seen[i-1] = PS2_DAT;
      repeat (3) @(negedge clk);
    end
    if (stop_after == 0) begin
      if (!nack) dev_dat_low = 1'b1;
      repeat (2) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (3) @(negedge clk);
      dev_dat_low = 1'b0;
    end
    wait_idle("frame_back_to_idle");
    nd = done_cnt - d0;
    ne = err_cnt - e0;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         nack;
    logic [9:0] exp_bits;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [9:0] seen;
    int         inh, nd, ne, gap, d0, e0, w;
    logic       dat_early, start_bit;

    vecs[0] = '{8'hED, 1'b0, 10'h3ED, 1, 0};
    vecs[1] = '{8'h01, 1'b0, 10'h201, 1, 0};
    vecs[2] = '{8'h00, 1'b0, 10'h300, 1, 0};
    vecs[3] = '{8'hFF, 1'b0, 10'h3FF, 1, 0};
    vecs[4] = '{8'hED, 1'b1, 10'h3ED, 0, 1};

    rst = 1'b1;
    txStart = 1'b0;
    txData = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_txBusy", {31'd0, txBusy}, 32'd0);
    chk("reset_txDone", {31'd0, txDone}, 32'd0);
    chk("reset_txError", {31'd0, txError}, 32'd0);
    chk("reset_clk_drive", {31'd0, ps2ClkDriveLow}, 32'd0);
    chk("reset_dat_drive", {31'd0, ps2DatDriveLow}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].data, vecs[v].nack, 0, 1'b0, seen, inh, dat_early, start_bit, nd, ne, gap);
      chk($sformatf("v%0d_bits", v), {22'd0, seen}, {22'd0, vecs[v].exp_bits});
      chk($sformatf("v%0d_inhibit_len", v), inh, 32'd20);
      chk($sformatf("v%0d_dat_early", v), {31'd0, dat_early}, 32'd0);
      chk($sformatf("v%0d_start_bit", v), {31'd0, start_bit}, 32'd0);
      chk($sformatf("v%0d_done_pulses", v), nd, vecs[v].exp_done);
      chk($sformatf("v%0d_error_pulses", v), ne, vecs[v].exp_err);
      chk($sformatf("v%0d_busy_at_pulse", v), {31'd0, busy_at_pulse}, 32'd1);
      chk($sformatf("v%0d_busy_after_pulse", v), {31'd0, busy_after_pulse}, 32'd0);
      chk($sformatf("v%0d_released", v), {31'd0, rel_after_pulse}, 32'd1);
    end

    // Timeout: 200 cycles after the last rising edge, plus 2 cycles of input synchroniser.
    run_frame(8'h00, 1'b0, 4, 1'b0, seen, inh, dat_early, start_bit, nd, ne, gap);
    chk("tmo_gap", gap, 32'd202);
    chk("tmo_error_pulses", ne, 32'd1);
    chk("tmo_done_pulses", nd, 32'd0);
    chk("tmo_released", {31'd0, rel_after_pulse}, 32'd1);

    run_frame(8'hED, 1'b0, 0, 1'b1, seen, inh, dat_early, start_bit, nd, ne, gap);
    chk("poke_bits", {22'd0, seen}, 32'h3ED);
    chk("poke_done_pulses", nd, 32'd1);
    chk("poke_error_pulses", ne, 32'd0);
    run_frame(8'h55, 1'b0, 0, 1'b0, seen, inh, dat_early, start_bit, nd, ne, gap);
    chk("next_bits", {22'd0, seen}, 32'h355);
    chk("next_done_pulses", nd, 32'd1);

    // Reset while D0=0 is being presented.
    @(negedge clk);
    txData  = 8'h00;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    w = 0;
    while (ps2ClkDriveLow && w < 1000) begin
      w++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_pre_dat_drive", {31'd0, ps2DatDriveLow}, 32'd1);
    d0 = done_cnt;
    e0 = err_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, txBusy}, 32'd0);
    chk("rst_clk_drive", {31'd0, ps2ClkDriveLow}, 32'd0);
    chk("rst_dat_drive", {31'd0, ps2DatDriveLow}, 32'd0);
    dev_clk_low = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 32'd0);
    chk("rst_no_error", err_cnt - e0, 32'd0);
    run_frame(8'hF4, 1'b0, 0, 1'b0, seen, inh, dat_early, start_bit, nd, ne, gap);
    chk("fresh_bits", {22'd0, seen}, 32'h2F4);
    chk("fresh_done_pulses", nd, 32'd1);
    chk("fresh_error_pulses", ne, 32'd0);

    chk("no_done_with_error", both_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
